// File: rtl/sodor_mon_pkg.sv
// Shared encodings and defaults for the Sodor tohost end-of-test monitor.
// BUS_W is taken from the global SIZE_OF_THE_BUS define when one is provided.
`ifndef SIZE_OF_THE_BUS
`define SIZE_OF_THE_BUS 32
`endif

package sodor_mon_pkg;

    typedef enum logic [2:0] {
        ST_WAIT    = 3'd0,
        ST_RUN     = 3'd1,
        ST_PASS    = 3'd2,
        ST_FAIL    = 3'd3,
        ST_TIMEOUT = 3'd4,
        ST_HANG    = 3'd5
    } mon_state_e;

    localparam logic [2:0]  MT_W                = 3'd3;
    localparam logic [31:0] TOHOST_ADDR_DEFAULT = 32'h0000_1000;

    function automatic logic is_terminal(input mon_state_e st);
        logic term;
        case (st)
            ST_PASS, ST_FAIL, ST_TIMEOUT, ST_HANG: term = 1'b1;
            default:                               term = 1'b0;
        endcase
        return term;
    endfunction

endpackage

// File: rtl/sodor_mon_hang_detect.sv
// PC-stall detector: flags the fourth/Nth consecutive cycle on which the fetch
// address equals the previous one. Only instantiated with SODOR_MON_HANG_DETECT_EN.
module sodor_mon_hang_detect #(
    parameter int ADDR_W      = 32,
    parameter int HANG_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [ADDR_W-1:0] addr,
    output logic              hang_hit
);

    localparam int                  STALL_W    = $clog2(HANG_CYCLES) + 1;
    localparam logic [STALL_W-1:0]  STALL_LAST = STALL_W'(HANG_CYCLES - 1);
    localparam logic [STALL_W-1:0]  STALL_ONE  = {{(STALL_W-1){1'b0}}, 1'b1};

    logic [ADDR_W-1:0]  prev_addr_r;
    logic [STALL_W-1:0] stall_cnt_r;
    logic               same_s;

    assign same_s   = (addr == prev_addr_r);
    assign hang_hit = en & same_s & (stall_cnt_r == STALL_LAST);

    // Previous-address register and saturating count of consecutive equal cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_addr_r <= {ADDR_W{1'b0}};
            stall_cnt_r <= {STALL_W{1'b0}};
        end else begin
            prev_addr_r <= addr;
            if (!en || !same_s) begin
                stall_cnt_r <= {STALL_W{1'b0}};
            end else if (stall_cnt_r != STALL_LAST) begin
                stall_cnt_r <= stall_cnt_r + STALL_ONE;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
        end
    end

endmodule

// File: rtl/sodor_tohost_monitor.sv
// Passive end-of-test observer: snoops word stores to tohost and reports
// pass/fail/timeout (and PC hang when SODOR_MON_HANG_DETECT_EN is defined).
`ifndef SIZE_OF_THE_BUS
`define SIZE_OF_THE_BUS 32
`endif

module sodor_tohost_monitor
    import sodor_mon_pkg::*;
#(
    parameter int               BUS_W          = `SIZE_OF_THE_BUS,
    parameter logic [BUS_W-1:0] TOHOST_ADDR    = BUS_W'(TOHOST_ADDR_DEFAULT),
    parameter int               TIMEOUT_CYCLES = 100000,
    parameter int               CNT_W          = 32,
    parameter int               HANG_CYCLES    = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [BUS_W-1:0] imem_req_addr,
    input  logic             dmem_req_valid,
    input  logic             dmem_req_write_en,
    input  logic [BUS_W-1:0] dmem_req_addr,
    input  logic [BUS_W-1:0] dmem_req_data,
    input  logic [2:0]       dmem_req_bits_typ,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic [BUS_W-1:0] fail_code,
    output logic             timeout,
    output logic             hang,
    output logic [CNT_W-1:0] cycle_count
);

    localparam logic [BUS_W-1:0] DATA_ONE     = {{(BUS_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 32'sd1);

    mon_state_e       state_r;
    mon_state_e       next_state_s;
    logic [BUS_W-1:0] fail_code_r;
    logic [BUS_W-1:0] next_fail_code_s;
    logic [CNT_W-1:0] cycle_count_r;
    logic             done_r;
    logic             pass_r;
    logic             fail_r;
    logic             timeout_r;
    logic             hang_r;

    logic             tohost_hit_s;
    logic             term_pass_s;
    logic             term_fail_s;
    logic             timeout_hit_s;
    logic             hang_hit_s;
    logic             in_run_s;

    assign in_run_s      = (state_r == ST_RUN);
    assign tohost_hit_s  = dmem_req_valid & dmem_req_write_en
                         & (dmem_req_addr == TOHOST_ADDR)
                         & (dmem_req_bits_typ == MT_W);
    assign term_pass_s   = tohost_hit_s & (dmem_req_data == DATA_ONE);
    // Even values are syscall/console traffic and never end the test.
    assign term_fail_s   = tohost_hit_s & dmem_req_data[0] & (dmem_req_data != DATA_ONE);
    assign timeout_hit_s = (cycle_count_r == TIMEOUT_LAST);

`ifdef SODOR_MON_HANG_DETECT_EN
    sodor_mon_hang_detect #(
        .ADDR_W      (BUS_W),
        .HANG_CYCLES (HANG_CYCLES)
    ) u_hang_detect (
        .clk      (clk),
        .rst      (rst),
        .en       (in_run_s),
        .addr     (imem_req_addr),
        .hang_hit (hang_hit_s)
    );
`else
    localparam int unused_hang_cycles_p = HANG_CYCLES;
    logic unused_imem_s;
    assign unused_imem_s = ^imem_req_addr;
    assign hang_hit_s    = 1'b0;
`endif

    // Next-state decode; priority is terminating hit, then timeout, then hang.
    always_comb begin
        next_state_s     = state_r;
        next_fail_code_s = fail_code_r;
        case (state_r)
            ST_WAIT: next_state_s = ST_RUN;
            ST_RUN: begin
                if (term_pass_s) begin
                    next_state_s = ST_PASS;
                end else if (term_fail_s) begin
                    next_state_s     = ST_FAIL;
                    next_fail_code_s = dmem_req_data >> 1'b1;
                end else if (timeout_hit_s) begin
                    next_state_s = ST_TIMEOUT;
                end else if (hang_hit_s) begin
                    next_state_s = ST_HANG;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_PASS, ST_FAIL, ST_TIMEOUT, ST_HANG: next_state_s = state_r;
            default: next_state_s = ST_WAIT;
        endcase
    end

    // State, registered status outputs and the RUN-cycle counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_WAIT;
            fail_code_r   <= {BUS_W{1'b0}};
            cycle_count_r <= {CNT_W{1'b0}};
            done_r        <= 1'b0;
            pass_r        <= 1'b0;
            fail_r        <= 1'b0;
            timeout_r     <= 1'b0;
            hang_r        <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            fail_code_r <= next_fail_code_s;
            done_r      <= is_terminal(next_state_s);
            pass_r      <= (next_state_s == ST_PASS);
            fail_r      <= (next_state_s == ST_FAIL);
            timeout_r   <= (next_state_s == ST_TIMEOUT);
            hang_r      <= (next_state_s == ST_HANG);
            if (in_run_s && !(&cycle_count_r)) begin
                cycle_count_r <= cycle_count_r + CNT_ONE;
            end else begin
                cycle_count_r <= cycle_count_r;
            end
        end
    end

    assign done        = done_r;
    assign pass        = pass_r;
    assign fail        = fail_r;
    assign fail_code   = fail_code_r;
    assign timeout     = timeout_r;
    assign hang        = hang_r;
    assign cycle_count = cycle_count_r;

endmodule

// File: tb/tb_sodor_tohost_monitor.sv
// Directed bench for sodor_tohost_monitor with TIMEOUT_CYCLES=10 and HANG_CYCLES=4.
module tb_sodor_tohost_monitor;

`ifdef SODOR_MON_HANG_DETECT_EN
    localparam bit HANG_EN = 1'b1;
`else
    localparam bit HANG_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_req_addr = 32'h0000_0100;
    logic        dmem_req_valid = 1'b0;
    logic        dmem_req_write_en = 1'b0;
    logic [31:0] dmem_req_addr = 32'h0;
    logic [31:0] dmem_req_data = 32'h0;
    logic [2:0]  dmem_req_bits_typ = 3'd0;
    logic        done, pass, fail, timeout, hang;
    logic [31:0] fail_code;
    logic [31:0] cycle_count;

    int  n_vec = 0;
    int  n_err = 0;
    bit  hold_pc = 1'b0;

    sodor_tohost_monitor #(
        .BUS_W          (32),
        .TOHOST_ADDR    (32'h0000_1000),
        .TIMEOUT_CYCLES (10),
        .CNT_W          (32),
        .HANG_CYCLES    (4)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .imem_req_addr     (imem_req_addr),
        .dmem_req_valid    (dmem_req_valid),
        .dmem_req_write_en (dmem_req_write_en),
        .dmem_req_addr     (dmem_req_addr),
        .dmem_req_data     (dmem_req_data),
        .dmem_req_bits_typ (dmem_req_bits_typ),
        .done              (done),
        .pass              (pass),
        .fail              (fail),
        .fail_code         (fail_code),
        .timeout           (timeout),
        .hang              (hang),
        .cycle_count       (cycle_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic e_done, input logic e_pass,
                             input logic e_fail, input logic e_to, input logic e_hang,
                             input logic [31:0] e_code, input logic [31:0] e_cnt);
        check({tag, "/done"},    64'(done),        64'(e_done));
        check({tag, "/pass"},    64'(pass),        64'(e_pass));
        check({tag, "/fail"},    64'(fail),        64'(e_fail));
        check({tag, "/timeout"}, 64'(timeout),     64'(e_to));
        check({tag, "/hang"},    64'(hang),        64'(e_hang));
        check({tag, "/code"},    64'(fail_code),   64'(e_code));
        check({tag, "/count"},   64'(cycle_count), 64'(e_cnt));
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (!hold_pc) imem_req_addr = imem_req_addr + 32'd4;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic bus(input logic v, input logic we, input logic [31:0] a,
                       input logic [31:0] d, input logic [2:0] t);
        dmem_req_valid    = v;
        dmem_req_write_en = we;
        dmem_req_addr     = a;
        dmem_req_data     = d;
        dmem_req_bits_typ = t;
    endtask

    task automatic idle();
        bus(1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
    endtask

    // Assert rst mid-cycle, check the asynchronous clear, release it; the DUT is then in WAIT.
    task automatic do_reset(input string tag);
        idle();
        rst = 1'b1;
        #1;
        check_all(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'd0);
        tick();
        rst = 1'b0;
    endtask

    initial begin
        // Power-on reset
        tick();
        check_all("por", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'd0);
        rst = 1'b0;

        // Pass on the fifth RUN cycle; count freezes afterwards
        tick();
        ticks(4);
        check_all("pre_pass", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'd4);
        bus(1'b1, 1'b1, 32'h0000_1000, 32'h1, 3'd3);
        tick();
        idle();
        check_all("pass", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'd5);
        bus(1'b1, 1'b1, 32'h0000_1000, 32'h7, 3'd3);
        ticks(3);
        idle();
        check_all("pass_frozen", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'd5);

        // Async reset in PASS; a hit during the WAIT cycle is ignored
        do_reset("rst_pass");
        bus(1'b1, 1'b1, 32'h0000_1000, 32'h1, 3'd3);
        tick();
        idle();
        check_all("wait_hit", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'd0);
        tick();
        check_all("run1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'd1);

        // Odd tohost value 7 -> fail with code 3; later pass store ignored
        bus(1'b1, 1'b1, 32'h0000_1000, 32'h0000_0007, 3'd3);
        tick();
        idle();
        check_all("fail7", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h3, 32'd2);
        bus(1'b1, 1'b1, 32'h0000_1000, 32'h1, 3'd3);
        tick();
        idle();
        check_all("fail_sticky", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h3, 32'd2);

        // Non-hits: byte store, load, wrong address, even value; then a pass
        do_reset("rst_nonhit");
        tick();
        bus(1'b1, 1'b1, 32'h0000_1000, 32'h1, 3'd0);
        tick();
        check_all("byte_st", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'd1);
        bus(1'b1, 1'b0, 32'h0000_1000, 32'h1, 3'd3);
        tick();
        check_all("load", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'd2);
        bus(1'b1, 1'b1, 32'h0000_1004, 32'h1, 3'd3);
        tick();
        check_all("wrong_addr", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'd3);
        bus(1'b1, 1'b1, 32'h0000_1000, 32'h2, 3'd3);
        tick();
        check_all("even", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'd4);
        bus(1'b0, 1'b1, 32'h0000_1000, 32'h1, 3'd3);
        tick();
        check_all("not_valid", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'd5);
        bus(1'b1, 1'b1, 32'h0000_1000, 32'h1, 3'd3);
        tick();
        idle();
        check_all("pass_after", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'd6);

        // Watchdog: count reaches 9 on RUN cycle 10, timeout from the next cycle
        do_reset("rst_to");
        tick();
        ticks(9);
        check_all("to_pre", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'd9);
        tick();
        check_all("to", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'd10);
        ticks(2);
        check_all("to_frozen", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'd10);

        // Pass hit on the watchdog cycle wins over timeout
        do_reset("rst_to_pass");
        tick();
        ticks(9);
        bus(1'b1, 1'b1, 32'h0000_1000, 32'h1, 3'd3);
        tick();
        idle();
        check_all("to_vs_pass", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'd10);

        // Fail hit on the watchdog cycle also wins over timeout
        do_reset("rst_to_fail");
        tick();
        ticks(9);
        bus(1'b1, 1'b1, 32'h0000_1000, 32'h0000_0011, 3'd3);
        tick();
        idle();
        check_all("to_vs_fail", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h8, 32'd10);

        // Hang: fetch address held at 0x200 from RUN cycle 1
        do_reset("rst_hang");
        hold_pc = 1'b1;
        imem_req_addr = 32'h0000_01FC;
        tick();
        imem_req_addr = 32'h0000_0200;
        ticks(4);
        check_all("hang_pre", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'd4);
        tick();
        check_all("hang", HANG_EN, 1'b0, 1'b0, 1'b0, HANG_EN, 32'h0, 32'd5);

        // Hang with an address change on RUN cycle 3 restarting the stall count
        do_reset("rst_hang2");
        imem_req_addr = 32'h0000_01FC;
        tick();
        imem_req_addr = 32'h0000_0200;
        ticks(2);
        imem_req_addr = 32'h0000_0204;
        ticks(4);
        check_all("hang2_pre", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'd6);
        tick();
        check_all("hang2", HANG_EN, 1'b0, 1'b0, 1'b0, HANG_EN, 32'h0, 32'd7);
        ticks(3);
        check_all("hang2_late", 1'b1, 1'b0, 1'b0, !HANG_EN, HANG_EN, 32'h0,
                  HANG_EN ? 32'd7 : 32'd10);
        hold_pc = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
